// File: rtl/vga_pkg.sv
// Shared constants for the 800x600 pattern stage: geometry, 5-6-5 colours,
// mode encodings, debug snapshot layout and the colour-bar lookup.
package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int BOX_SIZE = 64;
  localparam int STEP     = 2;
  localparam int BAR_W    = H_ACTIVE / 8;

  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] MAGENTA = 16'hF81F;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] BLACK   = 16'h0000;

  localparam logic [1:0] MODE_BARS_BOX = 2'd0;
  localparam logic [1:0] MODE_BARS     = 2'd1;
  localparam logic [1:0] MODE_GRID     = 2'd2;
  localparam logic [1:0] MODE_WHITE    = 2'd3;

  // Box direction: FWD = right (x) / down (y), REV = left / up.
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Snapshot of all frame-level state, exported for observation.
  typedef struct packed {
    logic [10:0] box_x;
    logic [9:0]  box_y;
    logic        dir_x;
    logic        dir_y;
    logic [1:0]  mode;
    logic        pause;
  } dbg_t;

  // Eight equal-width bars picked by a compare chain (no divider).
  function automatic logic [15:0] bar_colour(input logic [10:0] col);
    if      (col < 11'(BAR_W))     return WHITE;
    else if (col < 11'(2 * BAR_W)) return YELLOW;
    else if (col < 11'(3 * BAR_W)) return CYAN;
    else if (col < 11'(4 * BAR_W)) return GREEN;
    else if (col < 11'(5 * BAR_W)) return MAGENTA;
    else if (col < 11'(6 * BAR_W)) return RED;
    else if (col < 11'(7 * BAR_W)) return BLUE;
    else                           return BLACK;
  endfunction

endpackage

// File: rtl/vga_pattern_module_if.sv
// Bus between the sync generator and the pattern stage.
// Ready_Sig is a pure qualifier: when 1 the column/row address names a
// visible pixel; there is no back-pressure, the sink consumes every CLK.
interface vga_pattern_module_if;
  logic        Ready_Sig;
  logic [10:0] Column_Addr_Sig;
  logic [9:0]  Row_Addr_Sig;
  logic        HSYNC_In;
  logic        VSYNC_In;
  logic [1:0]  Mode_Sel;
  logic        Pause_Sig;
  logic [4:0]  Red_Sig;
  logic [5:0]  Green_Sig;
  logic [4:0]  Blue_Sig;
  logic        HSYNC_Sig;
  logic        VSYNC_Sig;

  modport master (
    output Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, HSYNC_In, VSYNC_In,
           Mode_Sel, Pause_Sig,
    input  Red_Sig, Green_Sig, Blue_Sig, HSYNC_Sig, VSYNC_Sig
  );

  modport slave (
    input  Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, HSYNC_In, VSYNC_In,
           Mode_Sel, Pause_Sig,
    output Red_Sig, Green_Sig, Blue_Sig, HSYNC_Sig, VSYNC_Sig
  );
endinterface

// File: rtl/box_motion_module.sv
// Bouncing-square position: steps once per frame tick on each axis and
// reverses at the visible-area edges, clamping onto the edge it hit.
module box_motion_module
  import vga_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        Tick_Sig,
  input  logic        Pause_Sig,
  output logic [10:0] Box_X,
  output logic [9:0]  Box_Y,
  output logic        Dir_X,
  output logic        Dir_Y
);

  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] X_STEP = 11'(STEP);
  localparam logic [9:0]  Y_STEP = 10'(STEP);

  // Horizontal position and direction, advanced on unpaused frame ticks.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      Box_X <= '0;
      Dir_X <= DIR_FWD;
    end else if (Tick_Sig && !Pause_Sig) begin
      if (Dir_X == DIR_FWD) begin
        if (Box_X + X_STEP > X_MAX) begin
          Box_X <= X_MAX;
          Dir_X <= DIR_REV;
        end else begin
          Box_X <= Box_X + X_STEP;
        end
      end else begin
        if (Box_X < X_STEP) begin
          Box_X <= '0;
          Dir_X <= DIR_FWD;
        end else begin
          Box_X <= Box_X - X_STEP;
        end
      end
    end
  end

  // Vertical position and direction, independent of the horizontal axis.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      Box_Y <= '0;
      Dir_Y <= DIR_FWD;
    end else if (Tick_Sig && !Pause_Sig) begin
      if (Dir_Y == DIR_FWD) begin
        if (Box_Y + Y_STEP > Y_MAX) begin
          Box_Y <= Y_MAX;
          Dir_Y <= DIR_REV;
        end else begin
          Box_Y <= Box_Y + Y_STEP;
        end
      end else begin
        if (Box_Y < Y_STEP) begin
          Box_Y <= '0;
          Dir_Y <= DIR_FWD;
        end else begin
          Box_Y <= Box_Y - Y_STEP;
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_module.sv
// Pixel-colour stage behind the 800x600 sync generator. Two register stages:
// S1 captures the generator outputs, S2 holds colour plus the S1 syncs so the
// syncs leave the block aligned with the RGB they belong to.
module vga_pattern_module
  import vga_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST_n,
  vga_pattern_module_if.slave  vga,
  output dbg_t                 Dbg_State
);

  logic        s1_ready;
  logic [10:0] s1_col;
  logic [9:0]  s1_row;
  logic        s1_hsync;
  logic        s1_vsync;
  logic [1:0]  mode_q;
  logic        pause_q;
  logic        frame_tick;
  logic [10:0] box_x;
  logic [9:0]  box_y;
  logic        dir_x;
  logic        dir_y;
  logic        in_box;
  logic [15:0] pix_next;
  logic [15:0] s2_rgb;
  logic        s2_hsync;
  logic        s2_vsync;

  // Falling edge of the incoming vsync marks the start of a new frame.
  assign frame_tick = s1_vsync & ~vga.VSYNC_In;

  // S1: register the generator outputs; syncs idle high.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      s1_ready <= 1'b0;
      s1_col   <= '0;
      s1_row   <= '0;
      s1_hsync <= 1'b1;
      s1_vsync <= 1'b1;
    end else begin
      s1_ready <= vga.Ready_Sig;
      s1_col   <= vga.Column_Addr_Sig;
      s1_row   <= vga.Row_Addr_Sig;
      s1_hsync <= vga.HSYNC_In;
      s1_vsync <= vga.VSYNC_In;
    end
  end

  // Mode and pause only change on the frame tick so a frame is never mixed.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      mode_q  <= MODE_BARS_BOX;
      pause_q <= 1'b0;
    end else if (frame_tick) begin
      mode_q  <= vga.Mode_Sel;
      pause_q <= vga.Pause_Sig;
    end
  end

  // The freshly sampled pause decides whether this tick moves the box.
  box_motion_module u_box (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .Tick_Sig  (frame_tick),
    .Pause_Sig (vga.Pause_Sig),
    .Box_X     (box_x),
    .Box_Y     (box_y),
    .Dir_X     (dir_x),
    .Dir_Y     (dir_y)
  );

  // Box never extends past the visible area, so these sums cannot wrap.
  assign in_box = (s1_col >= box_x) && (s1_col < box_x + 11'(BOX_SIZE)) &&
                  (s1_row >= box_y) && (s1_row < box_y + 10'(BOX_SIZE));

  // Colour decode from S1 values; blanking forces black in every mode.
  always_comb begin
    pix_next = BLACK;
    if (s1_ready) begin
      case (mode_q)
        MODE_BARS_BOX: pix_next = in_box ? WHITE : bar_colour(s1_col);
        MODE_BARS:     pix_next = bar_colour(s1_col);
        MODE_GRID:     pix_next = ((s1_col[4:0] == 5'd0) || (s1_row[4:0] == 5'd0))
                                  ? WHITE : BLACK;
        default:       pix_next = WHITE;
      endcase
    end
  end

  // S2: colour and the matching syncs leave together.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      s2_rgb   <= BLACK;
      s2_hsync <= 1'b1;
      s2_vsync <= 1'b1;
    end else begin
      s2_rgb   <= pix_next;
      s2_hsync <= s1_hsync;
      s2_vsync <= s1_vsync;
    end
  end

  assign vga.Red_Sig   = s2_rgb[15:11];
  assign vga.Green_Sig = s2_rgb[10:5];
  assign vga.Blue_Sig  = s2_rgb[4:0];
  assign vga.HSYNC_Sig = s2_hsync;
  assign vga.VSYNC_Sig = s2_vsync;

  assign Dbg_State = {box_x, box_y, dir_x, dir_y, mode_q, pause_q};

endmodule
